// File: rtl/cook_timer_pkg.sv
// Shared definitions for the cook-timer datapath: countdown state encoding
// and the seconds-field geometry used by the core, interface and bench.
package cook_timer_pkg;

  localparam int SEC_MAX = 59;
  localparam int SEC_W   = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } cd_state_e;

endpackage

// File: rtl/cook_timer_core_if.sv
// Control/status bundle between the egg-timer control FSM (master) and the
// cook-timer datapath (slave). Clock and reset stay outside the bundle.
interface cook_timer_core_if #(
  parameter int MIN_W = 7
);
  import cook_timer_pkg::*;

  logic               sec_tick;
  logic               prog_mode;
  logic               increment_seconds;
  logic               increment_minutes;
  logic               load_timer;
  logic               main_timer_enable;
  logic [SEC_W-1:0]   set_seconds;
  logic [MIN_W-1:0]   set_minutes;
  logic [SEC_W-1:0]   count_seconds;
  logic [MIN_W-1:0]   count_minutes;
  logic               timer_done;

  modport master (
    output sec_tick, prog_mode, increment_seconds, increment_minutes,
           load_timer, main_timer_enable,
    input  set_seconds, set_minutes, count_seconds, count_minutes, timer_done
  );

  modport slave (
    input  sec_tick, prog_mode, increment_seconds, increment_minutes,
           load_timer, main_timer_enable,
    output set_seconds, set_minutes, count_seconds, count_minutes, timer_done
  );

endinterface

// File: rtl/cook_timer_core_setting_counter.sv
// One user-setting field (seconds or minutes): rising-edge detector on the
// increment button, modulo wrap counter, and optional hold-to-repeat logic
// enabled by the macro COOK_TIMER_AUTOREPEAT_EN.
module setting_counter #(
  parameter int MODULUS      = 60,
  parameter int WIDTH        = 6,
  parameter int REPEAT_DELAY = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sec_tick_i,
  input  logic             prog_mode_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MODULUS - 1);

  logic             inc_hist_q;
  logic [WIDTH-1:0] value_q, value_d;
  logic             edge_w;
  logic             bump_w;

  // The history register follows the button even outside prog_mode, so a
  // button already held when prog_mode rises does not count as a press.
  assign edge_w = inc_i & ~inc_hist_q;

`ifdef COOK_TIMER_AUTOREPEAT_EN
  localparam int                HOLD_W   = $clog2(REPEAT_DELAY + 1) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY);

  logic              held_w;
  logic              repeat_w;
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign held_w   = prog_mode_i & inc_i;
  assign repeat_w = held_w & sec_tick_i & ~edge_w & (hold_q == HOLD_MAX);
  assign bump_w   = prog_mode_i & (edge_w | repeat_w);

  // Hold counter: counts ticks while pressed, saturates at the repeat delay.
  always_comb begin
    hold_d = hold_q;
    if (!held_w) begin
      hold_d = '0;
    end else if (sec_tick_i && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{sec_tick_i, 32'(REPEAT_DELAY)};
  assign bump_w     = prog_mode_i & edge_w;
`endif

  // Wrap counter next value.
  always_comb begin
    value_d = value_q;
    if (bump_w) begin
      value_d = (value_q == TOP_V) ? '0 : value_q + WIDTH'(1);
    end
  end

  // Setting value and edge history registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q    <= '0;
      inc_hist_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      inc_hist_q <= inc_i;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/cook_timer_core.sv
// Cook-timer datapath: MM:SS setting counters plus the main countdown and its
// IDLE/RUN/EXPIRED state machine. timer_done is a registered level.
// Optional hold-to-repeat on the setting buttons: COOK_TIMER_AUTOREPEAT_EN.
module cook_timer_core #(
  parameter int MAX_MIN      = 99,
  parameter int MIN_W        = 7,
  parameter int REPEAT_DELAY = 2
) (
  input logic               clk,
  input logic               reset_n,
  cook_timer_core_if.slave  bus
);
  import cook_timer_pkg::*;

  logic [SEC_W-1:0] set_sec_w;
  logic [MIN_W-1:0] set_min_w;
  logic             set_zero_w;

  cd_state_e        state_q, state_d;
  logic [SEC_W-1:0] csec_q, csec_d;
  logic [MIN_W-1:0] cmin_q, cmin_d;
  logic             done_q, done_d;

  setting_counter #(
    .MODULUS      (SEC_MAX + 1),
    .WIDTH        (SEC_W),
    .REPEAT_DELAY (REPEAT_DELAY)
  ) u_set_sec (
    .clk         (clk),
    .reset_n     (reset_n),
    .sec_tick_i  (bus.sec_tick),
    .prog_mode_i (bus.prog_mode),
    .inc_i       (bus.increment_seconds),
    .value_o     (set_sec_w)
  );

  setting_counter #(
    .MODULUS      (MAX_MIN + 1),
    .WIDTH        (MIN_W),
    .REPEAT_DELAY (REPEAT_DELAY)
  ) u_set_min (
    .clk         (clk),
    .reset_n     (reset_n),
    .sec_tick_i  (bus.sec_tick),
    .prog_mode_i (bus.prog_mode),
    .inc_i       (bus.increment_minutes),
    .value_o     (set_min_w)
  );

  assign set_zero_w = (set_sec_w == '0) && (set_min_w == '0);

  // Countdown next state: load wins over everything, including a same-cycle tick.
  always_comb begin
    state_d = state_q;
    csec_d  = csec_q;
    cmin_d  = cmin_q;
    done_d  = done_q;
    if (bus.load_timer) begin
      csec_d = set_sec_w;
      cmin_d = set_min_w;
      if (set_zero_w) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        done_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
        end
        RUN: begin
          done_d = 1'b0;
          if (bus.main_timer_enable && bus.sec_tick) begin
            if (csec_q != '0) begin
              csec_d = csec_q - SEC_W'(1);
              if ((csec_q == SEC_W'(1)) && (cmin_q == '0)) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
              end
            end else if (cmin_q != '0) begin
              csec_d = SEC_W'(SEC_MAX);
              cmin_d = cmin_q - MIN_W'(1);
            end
          end
        end
        EXPIRED: begin
          csec_d = '0;
          cmin_d = '0;
          done_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Countdown state, count and done registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      csec_q  <= '0;
      cmin_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      csec_q  <= csec_d;
      cmin_q  <= cmin_d;
      done_q  <= done_d;
    end
  end

  assign bus.set_seconds   = set_sec_w;
  assign bus.set_minutes   = set_min_w;
  assign bus.count_seconds = csec_q;
  assign bus.count_minutes = cmin_q;
  assign bus.timer_done    = done_q;

endmodule

// File: tb/tb_cook_timer_core.sv
// Bench for cook_timer_core: directed scenarios plus randomized stimulus,
// checked by a scoreboard fed from a total-seconds reference model.
module tb_cook_timer_core;
  import cook_timer_pkg::*;

  localparam int MAX_MIN = 99;
  localparam int MIN_W   = 7;
  localparam int RD      = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cook_timer_core_if #(.MIN_W(MIN_W)) ifc ();

  cook_timer_core #(
    .MAX_MIN      (MAX_MIN),
    .MIN_W        (MIN_W),
    .REPEAT_DELAY (RD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  typedef struct {
    int ss;
    int sm;
    int cs;
    int cm;
    int d;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: settings as integers, countdown as total seconds.
  int m_ss, m_sm, m_total;
  bit m_run, m_done, m_prev_s, m_prev_m;
`ifdef COOK_TIMER_AUTOREPEAT_EN
  int m_hold_s, m_hold_m;
`endif

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit prog, input bit is, input bit im,
                            input bit ld, input bit en, input bit tk);
    exp_t e;
    bit   es, em;
    int   ns, nm;
    if (!rn) begin
      m_ss = 0; m_sm = 0; m_total = 0; m_run = 0; m_done = 0;
      m_prev_s = 0; m_prev_m = 0;
`ifdef COOK_TIMER_AUTOREPEAT_EN
      m_hold_s = 0; m_hold_m = 0;
`endif
    end else begin
      es = is && !m_prev_s;
      em = im && !m_prev_m;
      ns = m_ss;
      nm = m_sm;
      if (prog && es) ns = (m_ss + 1) % 60;
      if (prog && em) nm = (m_sm + 1) % (MAX_MIN + 1);
`ifdef COOK_TIMER_AUTOREPEAT_EN
      if (prog && is) begin
        if (tk) begin
          if (!es && m_hold_s >= RD) ns = (m_ss + 1) % 60;
          m_hold_s++;
        end
      end else m_hold_s = 0;
      if (prog && im) begin
        if (tk) begin
          if (!em && m_hold_m >= RD) nm = (m_sm + 1) % (MAX_MIN + 1);
          m_hold_m++;
        end
      end else m_hold_m = 0;
`endif
      if (ld) begin
        m_total = m_sm * 60 + m_ss;
        m_run   = (m_total != 0);
        m_done  = (m_total == 0);
      end else if (m_run && en && tk) begin
        m_total--;
        if (m_total == 0) begin
          m_run  = 0;
          m_done = 1;
        end
      end
      m_ss = ns;
      m_sm = nm;
      m_prev_s = is;
      m_prev_m = im;
    end
    e.ss = m_ss;
    e.sm = m_sm;
    e.cs = m_total % 60;
    e.cm = m_total / 60;
    e.d  = m_done ? 1 : 0;
    sb.push_back(e);
  endtask

  // One clock cycle: apply inputs, record the expectation, move past the edge.
  task automatic drive(input bit rn, input bit prog, input bit is, input bit im,
                       input bit ld, input bit en, input bit tk);
    reset_n               = rn;
    ifc.prog_mode         = prog;
    ifc.increment_seconds = is;
    ifc.increment_minutes = im;
    ifc.load_timer        = ld;
    ifc.main_timer_enable = en;
    ifc.sec_tick          = tk;
    model_step(rn, prog, is, im, ld, en, tk);
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_s(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic pulse_m(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, 0, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic ticks(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0, en, 1);
      drive(1, 0, 0, 0, 0, en, 0);
    end
  endtask

  // Scoreboard monitor: every edge that has an expectation is compared.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_set_seconds",   ifc.set_seconds,   e.ss);
      chk("sb_set_minutes",   ifc.set_minutes,   e.sm);
      chk("sb_count_seconds", ifc.count_seconds, e.cs);
      chk("sb_count_minutes", ifc.count_minutes, e.cm);
      chk("sb_timer_done",    ifc.timer_done,    e.d);
    end
  end

  initial begin
    bit rn, prog, is, im, ld, en, tk;
    prog = 0;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
    chk("reset_set_seconds", ifc.set_seconds, 0);
    chk("reset_count_minutes", ifc.count_minutes, 0);
    chk("reset_done", ifc.timer_done, 0);

    // Seconds wrap without carry; a held minutes button counts once.
    pulse_s(61);
    chk("wrap_set_seconds", ifc.set_seconds, 1);
    chk("wrap_set_minutes", ifc.set_minutes, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("held_set_minutes", ifc.set_minutes, 1);

    // 01:02 countdown to expiry.
    pulse_s(1);
    drive(1, 0, 0, 0, 1, 1, 0);
    chk("load_0102_min", ifc.count_minutes, 1);
    chk("load_0102_sec", ifc.count_seconds, 2);
    ticks(3, 1);
    chk("tick3_min", ifc.count_minutes, 0);
    chk("tick3_sec", ifc.count_seconds, 59);
    ticks(58, 1);
    chk("tick61_done", ifc.timer_done, 0);
    chk("tick61_sec", ifc.count_seconds, 1);
    drive(1, 0, 0, 0, 0, 1, 1);
    chk("tick62_done", ifc.timer_done, 1);
    ticks(20, 1);
    chk("expired_hold_done", ifc.timer_done, 1);
    chk("expired_hold_sec", ifc.count_seconds, 0);

    // 00:30 with pause.
    pulse_m(99);
    pulse_s(28);
    chk("set_0030_min", ifc.set_minutes, 0);
    chk("set_0030_sec", ifc.set_seconds, 30);
    drive(1, 0, 0, 0, 1, 0, 0);
    ticks(5, 0);
    chk("paused_sec", ifc.count_seconds, 30);
    ticks(3, 1);
    chk("resumed_sec", ifc.count_seconds, 27);
    chk("resumed_done", ifc.timer_done, 0);

    // Load of 00:00 expires at once; reload clears it.
    pulse_s(30);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("zero_load_done", ifc.timer_done, 1);
    pulse_s(5);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("reload_done", ifc.timer_done, 0);
    chk("reload_sec", ifc.count_seconds, 5);

    // Load beats a coincident tick; reset aborts a run.
    pulse_s(5);
    drive(1, 0, 0, 0, 1, 0, 0);
    pulse_s(50);
    pulse_m(2);
    chk("paused_at_10", ifc.count_seconds, 10);
    drive(1, 0, 0, 0, 1, 1, 1);
    chk("load_tick_min", ifc.count_minutes, 2);
    chk("load_tick_sec", ifc.count_seconds, 0);
    ticks(3, 1);
    chk("run_0157_sec", ifc.count_seconds, 57);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("midrun_reset_min", ifc.count_minutes, 0);
    chk("midrun_reset_set", ifc.set_minutes, 0);
    ticks(3, 1);
    chk("idle_after_reset_sec", ifc.count_seconds, 0);
    chk("idle_after_reset_done", ifc.timer_done, 0);

    // Holding the seconds button across five ticks.
    drive(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 0, 1);
      drive(1, 1, 1, 0, 0, 0, 0);
    end
    drive(1, 1, 0, 0, 0, 0, 0);
`ifdef COOK_TIMER_AUTOREPEAT_EN
    chk("hold_repeat_sec", ifc.set_seconds, 4);
`else
    chk("hold_repeat_sec", ifc.set_seconds, 1);
`endif

    // Randomized traffic.
    is = 0; im = 0; en = 1;
    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 19) == 0) prog = ~prog;
      if ($urandom_range(0, 3) == 0) is = ~is;
      if ($urandom_range(0, 3) == 0) im = ~im;
      if ($urandom_range(0, 9) == 0) en = ~en;
      ld = ($urandom_range(0, 29) == 0);
      tk = ($urandom_range(0, 3) == 0);
      drive(rn, prog, is, im, ld, en, tk);
    end

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
